// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the sub-word load/store unit.
//   lsu_state_t : sequencing FSM states (IDLE, RD, WR, RESP)
//   F3_*        : RV32I funct3 encodings for loads/stores
//   lsu_size_t  : access size decoded from funct3[1:0]
//   f3_size()   : funct3[1:0] -> access size
//   f3_legal()  : is this funct3 a legal code for a load / store
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } lsu_size_t;

  // Only funct3[1:0] carries size; funct3[2] is the unsigned flag.
  function automatic lsu_size_t f3_size(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store unit.
//   word        in  32  memory word (old word for RMW, read word for loads)
//   addr_lo     in  2   byte offset within the word
//   size        in      access size (byte / half / word)
//   is_unsigned in  1   zero-extend instead of sign-extend on loads
//   wdata       in  32  right-aligned store data
//   load_data   out 32  selected lane, sign/zero extended
//   merged      out 32  word with the target lane replaced by wdata
// Halfwords use addr_lo[1] only and words ignore addr_lo, so misaligned
// accesses that reach this block are force-aligned.
// -----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  lsu_size_t   size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sign_b;
  logic        sign_h;

  // NOTE: every signal driven here gets a default before the case, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    lane_b    = word[{addr_lo, 3'b000} +: 8];
    lane_h    = addr_lo[1] ? word[31:16] : word[15:0];
    sign_b    = lane_b[7] & ~is_unsigned;
    sign_h    = lane_h[15] & ~is_unsigned;
    load_data = word;
    merged    = word;
    case (size)
      SZ_B: begin
        load_data = {{24{sign_b}}, lane_b};
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_data = {{16{sign_h}}, lane_h};
        merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data = word;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_subword.sv
// -----------------------------------------------------------------------------
// lsu_subword
// RV32I load/store unit in front of a word-only data memory (asynchronous
// read, synchronous word write). Adds LB/LH/LBU/LHU extension and SB/SH
// read-modify-write; SW writes directly.
//   clk, rst                         clock, async active-high reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_we, req_funct3               store flag, RV32I access size/sign
//   req_addr, req_wdata              byte address, right-aligned store data
//   resp_valid/resp_rdata/resp_err   single-cycle response pulse
//   mem_addr                         word-aligned byte address to memory
//   mem_write_en/mem_write_data      one-cycle write strobe and merged word
//   mem_read_data                    combinational memory read data
// Sequences: load IDLE->RD->RESP, SW IDLE->WR->RESP,
//            SB/SH IDLE->RD->WR->RESP, rejected IDLE->RESP.
// Optional macro LSU_MISALIGN_TRAP_EN: reject misaligned LH/LHU/SH/LW/SW
// instead of force-aligning them.
// DATA_W is fixed at 32 by the lane logic.
// -----------------------------------------------------------------------------
module lsu_subword
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic              err_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] word_q;

  logic              f3_ok;
  logic              reject;
  logic              needs_read;
  logic [ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;

  assign f3_ok = f3_legal(req_we, req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    case (f3_size(req_funct3[1:0]))
      SZ_H:    misaligned = req_addr[0];
      SZ_W:    misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end
  assign reject = !f3_ok || misaligned;
`else
  assign reject = !f3_ok;
`endif

  // Everything except SW must read the word first: loads for the data,
  // SB/SH to preserve the untouched bytes.
  assign needs_read = !req_we || (f3_size(req_funct3[1:0]) != SZ_W);

  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

  lsu_align u_align (
    .word        (word_q),
    .addr_lo     (addr_q[1:0]),
    .size        (f3_size(f3_q[1:0])),
    .is_unsigned (f3_q[2]),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  // NOTE: state and latched fields use non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  // NOTE: the latched request fields are reset too, so the outputs decoded
  // from them are defined from the first cycle after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req_valid) begin
        addr_q  <= req_addr;
        f3_q    <= req_funct3;
        we_q    <= req_we;
        err_q   <= reject;
        wdata_q <= req_wdata;
      end
      if (state == S_RD) begin
        word_q <= mem_read_data;
      end
    end
  end

  // Outputs depend only on state and latched fields; req_* reach only the
  // next-state decision, never the memory port.
  always_comb begin
    state_nxt      = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_err       = 1'b0;
    resp_rdata     = '0;
    mem_addr       = '0;
    mem_write_en   = 1'b0;
    mem_write_data = '0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (reject)          state_nxt = S_RESP;
          else if (needs_read) state_nxt = S_RD;
          else                 state_nxt = S_WR;
        end
      end
      S_RD: begin
        mem_addr  = word_addr;
        state_nxt = we_q ? S_WR : S_RESP;
      end
      S_WR: begin
        mem_addr       = word_addr;
        mem_write_en   = 1'b1;
        mem_write_data = merged;
        state_nxt      = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (we_q || err_q) ? '0 : load_data;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_subword.sv
// -----------------------------------------------------------------------------
// tb_lsu_subword
// Directed and random requests against lsu_subword with a word memory model
// attached to its memory port. Expected results come from a reference copy
// of memory and byte/halfword arithmetic on it. Honours LSU_MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_lsu_subword;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  lsu_subword dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // Data memory: 64 words, asynchronous read, synchronous write; preload port.
  logic [31:0] mem [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;

  assign mem_read_data = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (pl_en)             mem[pl_idx] <= pl_data;
    else if (mem_write_en) mem[mem_addr[7:2]] <= mem_write_data;
  end

  logic [31:0] ref_mem [0:63];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One request with full expectation from the reference memory.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata_seen);
    logic [31:0] old, exp_rd, exp_wd, v, mask;
    logic        legal, misal, exp_err, got, any_ready, rerr;
    int          exp_lat, sh, n, lat, wr_cnt;
    logic [31:0] wr_data, wr_addr, rdata;
    old   = ref_mem[addr[7:2]];
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    misal = ((f3[1:0] == 2'd1) && addr[0]) || ((f3[1:0] == 2'd2) && (addr[1:0] != 2'd0));
`ifdef LSU_MISALIGN_TRAP_EN
    exp_err = !legal || misal;
`else
    exp_err = !legal;
`endif
    exp_rd = 32'h0;
    exp_wd = 32'h0;
    if (f3[1:0] == 2'd0) begin
      sh   = 8 * int'(addr[1:0]);
      mask = 32'hFF << sh;
      v    = (old >> sh) & 32'hFF;
      if (!f3[2] && v >= 32'd128) v = v - 32'd256;
      exp_wd = (old & ~mask) | ((wdata & 32'hFF) << sh);
    end else if (f3[1:0] == 2'd1) begin
      sh   = 16 * int'(addr[1]);
      mask = 32'hFFFF << sh;
      v    = (old >> sh) & 32'hFFFF;
      if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
      exp_wd = (old & ~mask) | ((wdata & 32'hFFFF) << sh);
    end else begin
      v      = old;
      exp_wd = wdata;
    end
    if (!we && !exp_err) exp_rd = v;
    if (exp_err)                   exp_lat = 1;
    else if (!we || f3 == 3'd2)    exp_lat = 2;
    else                           exp_lat = 3;

    @(negedge clk);
    check({tag, "_ready_idle"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    n = 0; got = 1'b0; any_ready = 1'b0; wr_cnt = 0; lat = 0;
    wr_data = 32'h0; wr_addr = 32'h0; rdata = 32'h0; rerr = 1'b0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      req_valid = 1'b0;
      any_ready |= req_ready;
      if (mem_write_en) begin
        wr_cnt++;
        wr_data = mem_write_data;
        wr_addr = mem_addr;
      end
      if (resp_valid) begin
        got   = 1'b1;
        lat   = n;
        rerr  = resp_err;
        rdata = resp_rdata;
      end
    end
    check({tag, "_resp_seen"}, {31'b0, got}, 32'd1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_err"}, {31'b0, rerr}, {31'b0, exp_err});
    check({tag, "_rdata"}, rdata, exp_rd);
    check({tag, "_ready_low"}, {31'b0, any_ready}, 32'd0);
    check({tag, "_wr_count"}, wr_cnt, (we && !exp_err) ? 1 : 0);
    if (we && !exp_err) begin
      check({tag, "_wr_data"}, wr_data, exp_wd);
      check({tag, "_wr_addr"}, wr_addr, {addr[31:2], 2'b00});
      ref_mem[addr[7:2]] = exp_wd;
    end
    rdata_seen = rdata;
  endtask

  initial begin
    logic [31:0] rd;
    int          n, wr_cnt, resp_cnt;
    logic        got;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    pl_en = 1'b0; pl_idx = 6'd0; pl_data = 32'h0;

    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    ref_mem[4]  = 32'h8433_22F1;   // 0x10
    ref_mem[8]  = 32'h1122_3344;   // 0x20
    ref_mem[12] = 32'h5555_9A7C;   // 0x30
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_idx = 6'(i); pl_data = ref_mem[i];
    end
    @(negedge clk);
    pl_en = 1'b0;

    // Reset values while reset is held.
    check("rst_ready",     {31'b0, req_ready},    32'd1);
    check("rst_resp_valid",{31'b0, resp_valid},   32'd0);
    check("rst_resp_err",  {31'b0, resp_err},     32'd0);
    check("rst_resp_rdata", resp_rdata,           32'd0);
    check("rst_mem_we",    {31'b0, mem_write_en}, 32'd0);
    check("rst_mem_addr",   mem_addr,             32'd0);
    check("rst_mem_wdata",  mem_write_data,       32'd0);
    rst = 1'b0;

    // Test-plan directed steps.
    do_req("lb_10",  1'b0, 3'b000, 32'h10, 32'h0, rd);
    check("lb_10_const", rd, 32'hFFFF_FFF1);
    do_req("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, rd);
    check("lbu_13_const", rd, 32'h0000_0084);
    do_req("sb_21",  1'b1, 3'b000, 32'h21, 32'h0000_00AB, rd);
    do_req("lw_20",  1'b0, 3'b010, 32'h20, 32'h0, rd);
    check("lw_20_const", rd, 32'h1122_AB44);
    do_req("sw_40",  1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, rd);
    do_req("lw_40",  1'b0, 3'b010, 32'h40, 32'h0, rd);
    check("lw_40_const", rd, 32'hDEAD_BEEF);
    do_req("lh_31",  1'b0, 3'b001, 32'h31, 32'h0, rd);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lh_31_const", rd, 32'h0000_0000);
`else
    check("lh_31_const", rd, 32'hFFFF_9A7C);
`endif
    do_req("ill_ld_011", 1'b0, 3'b011, 32'h10, 32'h0, rd);
    do_req("ill_st_100", 1'b1, 3'b100, 32'h14, 32'h1234_5678, rd);
    do_req("lhu_22",     1'b0, 3'b101, 32'h22, 32'h0, rd);

    // Back-to-back: req_valid held high across two LW requests.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    n = 0; got = 1'b0;
    while (!got && n < 8) begin
      @(negedge clk); n++;
      if (resp_valid) got = 1'b1;
    end
    check("b2b_first_lat", n, 2);
    check("b2b_first_data", resp_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("b2b_ready_after_resp", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    check("b2b_second_accepted", {31'b0, req_ready}, 32'd0);
    req_valid = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 8) begin
      @(negedge clk); n++;
      if (resp_valid) got = 1'b1;
    end
    check("b2b_second_lat_rem", n, 1);
    check("b2b_second_data", resp_rdata, 32'hDEAD_BEEF);

    // Reset during the RD cycle of an SH.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h22; req_wdata = 32'h0000_CAFE;
    @(negedge clk);
    req_valid = 1'b0;
    check("rmo_in_rd_addr", mem_addr, 32'h20);
    rst = 1'b1;
    #1;
    check("rmo_ready",     {31'b0, req_ready},    32'd1);
    check("rmo_mem_we",    {31'b0, mem_write_en}, 32'd0);
    check("rmo_resp_valid",{31'b0, resp_valid},   32'd0);
    check("rmo_mem_addr",   mem_addr,             32'd0);
    check("rmo_mem_wdata",  mem_write_data,       32'd0);
    check("rmo_resp_rdata", resp_rdata,           32'd0);
    @(negedge clk);
    rst = 1'b0;
    wr_cnt = 0; resp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_write_en) wr_cnt++;
      if (resp_valid)   resp_cnt++;
    end
    check("rmo_no_write", wr_cnt, 0);
    check("rmo_no_resp",  resp_cnt, 0);
    check("rmo_ready_after", {31'b0, req_ready}, 32'd1);

    // Random mix of loads, stores, illegal codes and misaligned addresses.
    for (int i = 0; i < 80; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 255));
      do_req($sformatf("rnd%0d", i), we, f3, addr, $urandom, rd);
    end

    // Final memory image must match the reference.
    @(negedge clk);
    for (int i = 0; i < 64; i++) check($sformatf("mem_w%0d", i), mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
